alu_mc: RTL and testbench
=========================

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter DATA_WIDTH, default 32: operand/result width; SHALL be even and >= 8.
REQ-002 Parameter OPCODE_LENGTH, default 5: width of op; SHALL be >= 5.
REQ-003 One clock; reset is synchronous and active-low.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 in_valid  input  1  request present on op/src_a/src_b.
REQ-007 in_ready  output  1  block accepts request this cycle.
REQ-008 op  input  OPCODE_LENGTH  operation code.
REQ-009 src_a, src_b  input  DATA_WIDTH each  operands A and B.
REQ-010 flush  input  1  abort in-flight operation, discard pending result.
REQ-011 out_valid  output  1  result/zero valid.
REQ-012 out_ready  input  1  consumer takes result this cycle.
REQ-013 result  output  DATA_WIDTH  operation result.
REQ-014 zero  output  1  high when result == 0, qualified by out_valid.

Function
REQ-015 Opcodes: 00000 AND, 00001 OR, 00010 ADD, 00011 XOR, 00100 SUB, 00101 SLT signed, 00110 SLTU, 00111 SLL, 01000 EQ, 01001 SRL, 01010 SRA, 01011 NE, 01100 MUL, 01101 MULH, 01110 MULHU, 10000 DIV, 10001 DIVU, 10010 REM, 10011 REMU; any other code SHALL yield result 0 as a fast op.
REQ-016 Legacy codes 0000/0010/0100/0101/1000 zero-extended keep their meaning; SLT is now signed.
REQ-017 Shifts use src_b[$clog2(DATA_WIDTH)-1:0] only; SLT/SLTU/EQ/NE return 1 or 0 zero-extended.
REQ-018 Add/sub/mul low wrap modulo 2^DATA_WIDTH; no overflow flag.
REQ-019 FSM states IDLE, BUSY, DONE; in_ready = (state == IDLE).
REQ-020 Accept = in_valid & in_ready; operands and op SHALL be captured on accept.
REQ-021 Fast ops (logic, add/sub, compare, shift, undefined, div special cases): IDLE -> DONE; out_valid the cycle after accept (latency 1).
REQ-022 MUL/MULH/MULHU and regular DIV/DIVU/REM/REMU: IDLE -> BUSY for exactly DATA_WIDTH cycles, then DONE; out_valid DATA_WIDTH+1 cycles after accept.
REQ-023 Iterative ops: unsigned radix-2 core; signed ops via magnitude of operands, result negated per RISC-V sign rules (quotient sign = sign A xor sign B, remainder sign = sign A).
REQ-024 Divide by zero: DIV/DIVU result all ones; REM/REMU result = src_a; latency 1.
REQ-025 Signed overflow (A = most negative, B = -1): DIV result = A, REM result = 0; latency 1.
REQ-026 DONE: result, zero, out_valid held stable until out_ready; DONE -> IDLE on out_ready; no accept in DONE.
REQ-027 flush in any state: next state IDLE, out_valid low next cycle, result discarded; flush overrides simultaneous in_valid (no accept that cycle).
REQ-028 in_valid during BUSY/DONE SHALL be ignored (in_ready low); op/src changes after accept SHALL not affect result.

Reset
REQ-029 rst_n low at a clock edge: state IDLE, out_valid 0, result 0, zero 0 (suppressed by out_valid), iteration counter 0; in_ready 1 from the first cycle after reset release.
REQ-030 Reset mid-BUSY or mid-DONE SHALL abandon the operation with no output produced.

Structure
REQ-031 Package alu_pkg SHALL hold the opcode enum/localparams (REQ-015), the FSM state typedef and the default widths.
REQ-032 One sub-module, muldiv_seq, SHALL implement the unsigned iterative shift-add multiplier / restoring divider with start, DATA_WIDTH-cycle count, done, 2*DATA_WIDTH product and quotient/remainder.
REQ-033 Fast-op datapath SHALL remain combinational inside alu_mc feeding the result register.

Verification
REQ-034 ADD 0x7FFFFFFF+1, out_ready=1 -> out_valid next cycle, result 0x80000000, zero 0; SUB 5-5 -> result 0, zero 1.
REQ-035 MULH 0xFFFFFFFF*0xFFFFFFFF -> result 0 after 33 cycles; MULHU same operands -> 0xFFFFFFFE; MUL -> 0x00000001.
REQ-036 DIV -7/2 -> 0xFFFFFFFD, REM -7/2 -> 0xFFFFFFFF (33 cycles); DIVU 10/0 -> 0xFFFFFFFF and REM 0x80000000/0xFFFFFFFF -> 0, each latency 1.
REQ-037 DIVU issued, out_ready held 0 for 5 cycles after out_valid -> result stable, in_ready 0 throughout; new in_valid ignored until the cycle after out_ready.
REQ-038 flush 10 cycles into MUL together with in_valid ADD 1+1 -> no output, in_ready 1 next cycle; rst_n low mid-DIV -> out_valid 0, in_ready 1 after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: default widths, opcode map and
// control FSM state encoding.
package alu_pkg;

    localparam int DATA_WIDTH_DEF    = 32;
    localparam int OPCODE_LENGTH_DEF = 5;

    typedef enum logic [4:0] {
        OP_AND   = 5'b00000,
        OP_OR    = 5'b00001,
        OP_ADD   = 5'b00010,
        OP_XOR   = 5'b00011,
        OP_SUB   = 5'b00100,
        OP_SLT   = 5'b00101,
        OP_SLTU  = 5'b00110,
        OP_SLL   = 5'b00111,
        OP_EQ    = 5'b01000,
        OP_SRL   = 5'b01001,
        OP_SRA   = 5'b01010,
        OP_NE    = 5'b01011,
        OP_MUL   = 5'b01100,
        OP_MULH  = 5'b01101,
        OP_MULHU = 5'b01110,
        OP_DIV   = 5'b10000,
        OP_DIVU  = 5'b10001,
        OP_REM   = 5'b10010,
        OP_REMU  = 5'b10011
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/muldiv_seq.sv
// Unsigned radix-2 iterative engine: shift-add multiplier or restoring divider.
// The final iteration is presented combinationally together with done.
module muldiv_seq import alu_pkg::*; #(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      abort,
    input  logic                      start,
    input  logic                      is_div,
    input  logic [DATA_WIDTH-1:0]     a,
    input  logic [DATA_WIDTH-1:0]     b,
    output logic                      done,
    output logic [2*DATA_WIDTH-1:0]   prod,
    output logic [DATA_WIDTH-1:0]     quot,
    output logic [DATA_WIDTH-1:0]     rem
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    logic          busy_r;
    logic          is_div_r;
    logic [CW-1:0] cnt_r;
    logic [W-1:0]  hi_r;
    logic [W-1:0]  lo_r;
    logic [W-1:0]  b_r;
    logic [W:0]    sum_s;
    logic [W:0]    shl_s;
    logic [W-1:0]  dif_s;
    logic          ge_s;
    logic [W-1:0]  hi_s;
    logic [W-1:0]  lo_s;

    // One iteration step; hi holds product-high / partial remainder, lo holds multiplier / quotient
    always_comb begin
        sum_s = {1'b0, hi_r} + (lo_r[0] ? {1'b0, b_r} : {(W+1){1'b0}});
        shl_s = {hi_r, lo_r[W-1]};
        dif_s = shl_s[W-1:0] - b_r;
        ge_s  = (shl_s >= {1'b0, b_r});
        if (is_div_r) begin
            hi_s = ge_s ? dif_s : shl_s[W-1:0];
            lo_s = {lo_r[W-2:0], ge_s};
        end else begin
            hi_s = sum_s[W:1];
            lo_s = {sum_s[0], lo_r[W-1:1]};
        end
    end

    assign done = busy_r & (cnt_r == CW'(W - 1));
    assign prod = {hi_s, lo_s};
    assign quot = lo_s;
    assign rem  = hi_s;

    // Operand load on start, then one step per busy cycle until the count expires
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_r   <= 1'b0;
            is_div_r <= 1'b0;
            cnt_r    <= '0;
            hi_r     <= '0;
            lo_r     <= '0;
            b_r      <= '0;
        end else if (abort) begin
            busy_r <= 1'b0;
            cnt_r  <= '0;
        end else if (start) begin
            busy_r   <= 1'b1;
            is_div_r <= is_div;
            cnt_r    <= '0;
            hi_r     <= '0;
            lo_r     <= a;
            b_r      <= b;
        end else if (busy_r) begin
            hi_r   <= hi_s;
            lo_r   <= lo_s;
            cnt_r  <= done ? '0 : cnt_r + CW'(1);
            busy_r <= ~done;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/compare/shift ops plus iterative
// multiply and divide, with valid/ready handshakes and flush.
module alu_mc import alu_pkg::*; #(
    parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int OPCODE_LENGTH = OPCODE_LENGTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OPCODE_LENGTH-1:0] op,
    input  logic [DATA_WIDTH-1:0]    src_a,
    input  logic [DATA_WIDTH-1:0]    src_b,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    result,
    output logic                     zero
);

    localparam int W  = DATA_WIDTH;
    localparam int SW = $clog2(DATA_WIDTH);

    state_t          state_r, state_s;
    opcode_t         op_s, op_r;
    logic            op_def_s, accept_s, iter_s, bz_s, ovf_s, neg_s, neg_r;
    logic            md_done_s, out_valid_r, zero_r;
    logic [SW-1:0]   shamt_s;
    logic [W-1:0]    fast_s, mag_a_s, mag_b_s, iter_res_s, result_s, result_r;
    logic [W-1:0]    quot_s, rem_s;
    logic [2*W-1:0]  prod_s, sprod_s;

    function automatic logic [W-1:0] mag(input logic [W-1:0] x);
        return x[W-1] ? (~x + W'(1)) : x;
    endfunction

    assign in_ready  = (state_r == ST_IDLE);
    assign accept_s  = in_valid & in_ready & ~flush;
    assign op_s      = opcode_t'(op[4:0]);
    assign op_def_s  = (op == OPCODE_LENGTH'(op[4:0]));
    assign shamt_s   = src_b[SW-1:0];
    assign bz_s      = (src_b == '0);
    assign ovf_s     = (src_a == {1'b1, {(W-1){1'b0}}}) & (src_b == '1);
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign zero      = zero_r;

    // Fast-op datapath and classification of requests that need the iterative engine
    always_comb begin
        fast_s  = '0;
        iter_s  = 1'b0;
        neg_s   = 1'b0;
        mag_a_s = src_a;
        mag_b_s = src_b;
        if (op_def_s) begin
            case (op_s)
                OP_AND:   fast_s = src_a & src_b;
                OP_OR:    fast_s = src_a | src_b;
                OP_ADD:   fast_s = src_a + src_b;
                OP_XOR:   fast_s = src_a ^ src_b;
                OP_SUB:   fast_s = src_a - src_b;
                OP_SLT:   fast_s = W'($signed(src_a) < $signed(src_b));
                OP_SLTU:  fast_s = W'(src_a < src_b);
                OP_SLL:   fast_s = src_a << shamt_s;
                OP_EQ:    fast_s = W'(src_a == src_b);
                OP_SRL:   fast_s = src_a >> shamt_s;
                OP_SRA:   fast_s = W'($signed(src_a) >>> shamt_s);
                OP_NE:    fast_s = W'(src_a != src_b);
                OP_MUL, OP_MULHU: iter_s = 1'b1;
                OP_MULH: begin
                    iter_s  = 1'b1;
                    neg_s   = src_a[W-1] ^ src_b[W-1];
                    mag_a_s = mag(src_a);
                    mag_b_s = mag(src_b);
                end
                OP_DIV: begin
                    if (bz_s) begin
                        fast_s = '1;
                    end else if (ovf_s) begin
                        fast_s = src_a;
                    end else begin
                        iter_s  = 1'b1;
                        neg_s   = src_a[W-1] ^ src_b[W-1];
                        mag_a_s = mag(src_a);
                        mag_b_s = mag(src_b);
                    end
                end
                OP_DIVU: begin
                    if (bz_s) fast_s = '1;
                    else      iter_s = 1'b1;
                end
                OP_REM: begin
                    if (bz_s) begin
                        fast_s = src_a;
                    end else if (ovf_s) begin
                        fast_s = '0;
                    end else begin
                        iter_s  = 1'b1;
                        neg_s   = src_a[W-1];
                        mag_a_s = mag(src_a);
                        mag_b_s = mag(src_b);
                    end
                end
                OP_REMU: begin
                    if (bz_s) fast_s = src_a;
                    else      iter_s = 1'b1;
                end
                default:  fast_s = '0;
            endcase
        end else begin
            fast_s = '0;
        end
    end

    muldiv_seq #(.DATA_WIDTH(W)) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .abort  (flush),
        .start  (accept_s & iter_s),
        .is_div (op[4]),
        .a      (mag_a_s),
        .b      (mag_b_s),
        .done   (md_done_s),
        .prod   (prod_s),
        .quot   (quot_s),
        .rem    (rem_s)
    );

    // Sign restore and selection of the iterative result (negation on the full product for MULH)
    always_comb begin
        sprod_s = neg_r ? (~prod_s + (2*W)'(1)) : prod_s;
        case (op_r)
            OP_MUL:            iter_res_s = sprod_s[W-1:0];
            OP_MULH, OP_MULHU: iter_res_s = sprod_s[2*W-1:W];
            OP_DIV, OP_DIVU:   iter_res_s = neg_r ? (~quot_s + W'(1)) : quot_s;
            OP_REM, OP_REMU:   iter_res_s = neg_r ? (~rem_s + W'(1)) : rem_s;
            default:           iter_res_s = '0;
        endcase
    end

    // Next state; flush wins over everything
    always_comb begin
        state_s = state_r;
        if (flush) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: state_s = in_valid ? (iter_s ? ST_BUSY : ST_DONE) : ST_IDLE;
                ST_BUSY: state_s = md_done_s ? ST_DONE : ST_BUSY;
                ST_DONE: state_s = out_ready ? ST_IDLE : ST_DONE;
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // Next result value; held otherwise so DONE presents a stable output
    always_comb begin
        result_s = result_r;
        if (accept_s && !iter_s) begin
            result_s = fast_s;
        end else if ((state_r == ST_BUSY) && md_done_s && !flush) begin
            result_s = iter_res_s;
        end else begin
            result_s = result_r;
        end
    end

    // State, captured request attributes and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            op_r        <= OP_AND;
            neg_r       <= 1'b0;
            result_r    <= '0;
            zero_r      <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            result_r    <= result_s;
            out_valid_r <= (state_s == ST_DONE);
            zero_r      <= (state_s == ST_DONE) && (result_s == '0);
            if (accept_s) begin
                op_r  <= op_s;
                neg_r <= neg_s;
            end
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed vector table, randomized ops against
// an arithmetic reference model, and handshake/flush/reset sequences.
module tb_alu_mc;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, flush, out_valid, out_ready, zero;
    logic [4:0]  op;
    logic [31:0] src_a, src_b, result;
    int          n_vec = 0;
    int          n_err = 0;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t tbl [22];

    always #5 clk = ~clk;

    alu_mc #(.DATA_WIDTH(32), .OPCODE_LENGTH(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .src_a     (src_a),
        .src_b     (src_b),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, sp;
        longint unsigned up;
        logic signed [31:0] t;
        logic            ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        up  = {32'h0, a} * {32'h0, b};
        sp  = sa * sb;
        t   = a;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (o)
            5'd0:  return a & b;
            5'd1:  return a | b;
            5'd2:  return a + b;
            5'd3:  return a ^ b;
            5'd4:  return a - b;
            5'd5:  return (sa < sb) ? 32'd1 : 32'd0;
            5'd6:  return (a < b) ? 32'd1 : 32'd0;
            5'd7:  return a << b[4:0];
            5'd8:  return (a == b) ? 32'd1 : 32'd0;
            5'd9:  return a >> b[4:0];
            5'd10: return t >>> b[4:0];
            5'd11: return (a != b) ? 32'd1 : 32'd0;
            5'd12: return up[31:0];
            5'd13: return sp[63:32];
            5'd14: return up[63:32];
            5'd16: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                sp = sa / sb;
                return sp[31:0];
            end
            5'd17: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            5'd18: begin
                if (b == 32'd0) return a;
                if (ovf) return 32'd0;
                sp = sa % sb;
                return sp[31:0];
            end
            5'd19: return (b == 32'd0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int model_lat(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        logic ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        if (o == 5'd12 || o == 5'd13 || o == 5'd14) return 33;
        if ((o == 5'd16 || o == 5'd18) && b != 32'd0 && !ovf) return 33;
        if ((o == 5'd17 || o == 5'd19) && b != 32'd0) return 33;
        return 1;
    endfunction

    // Issue one request with out_ready high; returns result, zero and observed latency (-1 on timeout)
    task automatic run_vec(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] res, output logic z, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        in_valid  = 1'b1;
        op        = o;
        src_a     = a;
        src_b     = b;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        op       = 5'($urandom);
        src_a    = $urandom;
        src_b    = $urandom;
        lat      = 1;
        while (!out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        res = result;
        z   = zero;
        if (!out_valid) lat = -1;
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    initial begin
        logic [31:0] res;
        logic        z;
        int          lat, seen;
        logic [4:0]  ops [23];
        logic [31:0] a, b, exp_v;

        tbl[0]  = '{5'b00010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1};
        tbl[1]  = '{5'b00100, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1};
        tbl[2]  = '{5'b01101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33};
        tbl[3]  = '{5'b01110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
        tbl[4]  = '{5'b01100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33};
        tbl[5]  = '{5'b10000, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33};
        tbl[6]  = '{5'b10010, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33};
        tbl[7]  = '{5'b10001, 32'h0000_000A, 32'h0000_0000, 32'hFFFF_FFFF, 1};
        tbl[8]  = '{5'b10010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
        tbl[9]  = '{5'b10000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        tbl[10] = '{5'b10011, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 1};
        tbl[11] = '{5'b00101, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1};
        tbl[12] = '{5'b00110, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1};
        tbl[13] = '{5'b01010, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1};
        tbl[14] = '{5'b00111, 32'h0000_0003, 32'h0000_0021, 32'h0000_0006, 1};
        tbl[15] = '{5'b01111, 32'h0000_FFFF, 32'h0000_0001, 32'h0000_0000, 1};
        tbl[16] = '{5'b01000, 32'h0000_0005, 32'h0000_0005, 32'h0000_0001, 1};
        tbl[17] = '{5'b01011, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1};
        tbl[18] = '{5'b10001, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 33};
        tbl[19] = '{5'b10011, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 33};
        tbl[20] = '{5'b01001, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1};
        tbl[21] = '{5'b01101, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF, 33};

        for (int i = 0; i < 20; i++) ops[i] = (i < 15) ? 5'(i) : 5'(i + 1);
        ops[20] = 5'b01111;
        ops[21] = 5'b10100;
        ops[22] = 5'b11111;

        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        op = 5'd0; src_a = 32'd0; src_b = 32'd0;
        repeat (3) @(negedge clk);
        check("reset out_valid", {63'd0, out_valid}, 64'd0);
        check("reset result", {32'd0, result}, 64'd0);
        check("reset zero", {63'd0, zero}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready after reset", {63'd0, in_ready}, 64'd1);

        for (int i = 0; i < 22; i++) begin
            run_vec(tbl[i].op, tbl[i].a, tbl[i].b, res, z, lat);
            check($sformatf("tbl%0d result", i), {32'd0, res}, {32'd0, tbl[i].exp});
            check($sformatf("tbl%0d zero", i), {63'd0, z}, {63'd0, (tbl[i].exp == 32'd0)});
            check($sformatf("tbl%0d latency", i), 64'(lat), 64'(tbl[i].lat));
        end

        for (int i = 0; i < 150; i++) begin
            logic [4:0] o;
            o = ops[$urandom_range(0, 22)];
            a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 4))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            exp_v = model(o, a, b);
            run_vec(o, a, b, res, z, lat);
            check($sformatf("rnd%0d op%0d result", i, o), {32'd0, res}, {32'd0, exp_v});
            check($sformatf("rnd%0d zero", i), {63'd0, z}, {63'd0, (exp_v == 32'd0)});
            check($sformatf("rnd%0d latency", i), 64'(lat), 64'(model_lat(o, a, b)));
        end

        // Back-pressure: DIVU held in DONE for 5 cycles while new requests are offered
        in_valid = 1'b1; op = 5'b10001; src_a = 32'd100; src_b = 32'd7; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        check("stall latency", 64'(lat), 64'd33);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; op = 5'b00010; src_a = 32'd2; src_b = 32'd3;
            @(negedge clk);
            check($sformatf("stall%0d result", k), {32'd0, result}, 64'd14);
            check($sformatf("stall%0d out_valid", k), {63'd0, out_valid}, 64'd1);
            check($sformatf("stall%0d in_ready", k), {63'd0, in_ready}, 64'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("release out_valid", {63'd0, out_valid}, 64'd0);
        check("release in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("post-release add valid", {63'd0, out_valid}, 64'd1);
        check("post-release add result", {32'd0, result}, 64'd5);
        @(negedge clk);

        // Flush while idle overrides a simultaneous request
        flush = 1'b1; in_valid = 1'b1; op = 5'b00010; src_a = 32'd1; src_b = 32'd1;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        check("idle flush out_valid", {63'd0, out_valid}, 64'd0);
        check("idle flush in_ready", {63'd0, in_ready}, 64'd1);

        // Flush 10 cycles into a MUL together with an ADD request
        in_valid = 1'b1; op = 5'b01100; src_a = 32'd3; src_b = 32'd4;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("mul busy in_ready", {63'd0, in_ready}, 64'd0);
        flush = 1'b1; in_valid = 1'b1; op = 5'b00010; src_a = 32'd1; src_b = 32'd1;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        check("flush in_ready", {63'd0, in_ready}, 64'd1);
        check("flush out_valid", {63'd0, out_valid}, 64'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("flush no output", 64'(seen), 64'd0);

        // Reset in the middle of a DIV
        in_valid = 1'b1; op = 5'b10000; src_a = 32'd100; src_b = 32'd3;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("mid-div reset out_valid", {63'd0, out_valid}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid-div reset in_ready", {63'd0, in_ready}, 64'd1);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("mid-div reset no output", 64'(seen), 64'd0);

        run_vec(5'b00011, 32'hA5A5_0000, 32'h0000_5A5A, res, z, lat);
        check("after reset xor", {32'd0, res}, 64'hA5A5_5A5A);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
